// File: rtl/demux_1to4_sequencer_if.sv
// Handshake and demux-side bundle for demux_1to4_sequencer.
// master drives the serial stream and enable mask; slave is the sequencer.
interface demux_1to4_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_data;
    logic             in_ready;
    logic [3:0]       ch_en;
    logic             i;
    logic             s1;
    logic             s0;
    logic             out_valid;
    logic [CNT_W-1:0] beat_total;

    modport master (
        output in_valid,
        output in_data,
        output ch_en,
        input  in_ready,
        input  i,
        input  s1,
        input  s0,
        input  out_valid,
        input  beat_total
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  ch_en,
        output in_ready,
        output i,
        output s1,
        output s0,
        output out_valid,
        output beat_total
    );
endinterface

// File: rtl/demux_1to4_sequencer.sv
// Feeds a 1-to-4 demux: accepts serial bits over valid/ready and delivers them
// round-robin over the enabled channels, DWELL beats per channel.
module demux_1to4_sequencer #(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    demux_1to4_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SKIP
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t           state;
    logic [1:0]       ptr;
    logic [7:0]       dwell_cnt;
    logic             i_q;
    logic [1:0]       sel_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] beat_total_q;

    logic             in_ready_c;
    logic             accept;
    logic [1:0]       adv_target;
    logic [1:0]       skip_target;

    // First enabled channel after 'from', wrapping back to 'from' itself last.
    function automatic logic [1:0] next_enabled(input logic [1:0] from,
                                                input logic [3:0] en);
        logic [1:0] pick;
        logic [1:0] cand;
        logic       found;
        pick  = from;
        found = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = from + 2'(k);
            if (!found && en[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        in_ready_c  = (state == RUN) && bus.ch_en[ptr];
        accept      = bus.in_valid && in_ready_c;
        adv_target  = next_enabled(ptr, bus.ch_en);
        // Arriving from IDLE the current channel may already be enabled; keep it.
        skip_target = bus.ch_en[ptr] ? ptr : adv_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            dwell_cnt    <= '0;
            i_q          <= 1'b0;
            sel_q        <= '0;
            out_valid_q  <= 1'b0;
            beat_total_q <= '0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                i_q          <= bus.in_data;
                sel_q        <= ptr;
                beat_total_q <= beat_total_q + CNT_W'(1);
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_cnt <= '0;
                    ptr       <= adv_target;
                end else begin
                    dwell_cnt <= dwell_cnt + 8'd1;
                end
            end else begin
                i_q <= 1'b0;
            end

            // Accepts only happen in RUN, and RUN never writes ptr/dwell_cnt here.
            unique case (state)
                IDLE: begin
                    if (bus.ch_en != 4'b0000) begin
                        state <= SKIP;
                    end
                end
                SKIP: begin
                    if (bus.ch_en == 4'b0000) begin
                        state <= IDLE;
                    end else begin
                        ptr       <= skip_target;
                        dwell_cnt <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (bus.ch_en == 4'b0000) begin
                        state <= IDLE;
                    end else if (!bus.ch_en[ptr]) begin
                        state <= SKIP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.i          = i_q;
    assign bus.s1         = sel_q[1];
    assign bus.s0         = sel_q[0];
    assign bus.out_valid  = out_valid_q;
    assign bus.beat_total = beat_total_q;

endmodule

// File: doc/demux_1to4_sequencer.md
# demux_1to4_sequencer

Upstream driver for the 1-to-4 demultiplexer: accepts a serial bit stream over a valid/ready handshake and presents each accepted bit on `i` together with the channel select `s1`/`s0`, one registered beat at a time. Channels are visited round-robin over an enable mask, each channel receiving `DWELL` consecutive beats before the pointer advances. The outputs connect directly to the demux inputs of the same names.

## Interface
- `DWELL`, 2: beats delivered to a channel before advancing; legal range 1..255.
- `CNT_W`, 8: width of the total-beat counter.

- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream bit available.
- `in_data` input 1: upstream bit.
- `in_ready` output 1: block accepts `in_data` this cycle.
- `ch_en` input 4: per-channel enable; bit k enables channel k (k = {s1,s0}).
- `i` output 1: data to demux.
- `s1` output 1: channel select MSB.
- `s0` output 1: channel select LSB.
- `out_valid` output 1: `i`/`s1`/`s0` carry a fresh beat this cycle.
- `beat_total` output CNT_W: count of accepted beats, wraps modulo 2^CNT_W.

## Operation
- Internal state: `ptr[1:0]` (current channel), `dwell_cnt[7:0]`, FSM state.
- FSM states: IDLE, RUN, SKIP.
  - IDLE: `ch_en == 0`. `in_ready = 0`. Go to SKIP when `ch_en != 0`.
  - SKIP: `ptr` channel disabled. Each cycle advance `ptr` to the next enabled channel, searching `ptr+1, ptr+2, ptr+3, ptr` circularly, clear `dwell_cnt`, go to RUN. If `ch_en == 0`, go to IDLE.
  - RUN: `in_ready = ch_en[ptr]`. If `ch_en == 0`, go to IDLE. If `ch_en[ptr] == 0`, go to SKIP.
- Accept = `in_valid && in_ready`. On accept:
  - `i <= in_data`, `{s1,s0} <= ptr`, `out_valid <= 1`, `beat_total <= beat_total + 1`.
  - If `dwell_cnt == DWELL-1`: `dwell_cnt <= 0` and `ptr` advances circularly to the next enabled channel. This may be the same channel if it is the only one enabled.
  - Otherwise: `dwell_cnt <= dwell_cnt + 1`.
- No accept: `out_valid <= 0`, `i <= 0`, and `s1`/`s0` hold their last value, so a select change never coincides with a glitching `i`.
- Enable-mask changes take effect on the cycle they are sampled. A beat accepted in the same cycle that its channel is disabled is still delivered.
- `beat_total` wraps from 2^CNT_W−1 to 0 silently.

## Timing
- Reset (async assert, sync release to `clk`): `i=0`, `s1=0`, `s0=0`, `out_valid=0`, `in_ready=0`, `beat_total=0`, `ptr=0`, `dwell_cnt=0`, state IDLE.
- `in_ready` is combinational from state, `ptr` and `ch_en`. It does not depend on `in_valid`.
- Latency: `in_data` accepted at edge N appears on `i` with `out_valid=1` from edge N to edge N+1. Latency is 1 cycle.
- Throughput: 1 beat/cycle in RUN, including across a channel advance (the advance is folded into the accepting edge).
- Leaving IDLE costs 1 cycle (SKIP) before the first accept. Each SKIP resolves in exactly 1 cycle.
- Reset mid-stream discards the in-flight beat. `out_valid` drops immediately when `rst_n` asserts.

## Test plan
- Reset, then `ch_en=4'b1111`, `DWELL=2`, `in_valid=1`, data 1,0,1,1,0,1,0,0:
  - `{s1,s0}` sequence 0,0,1,1,2,2,3,3.
  - `i` matches the data, delayed 1 cycle.
  - `beat_total=8`.
- `ch_en=4'b1010`, `DWELL=1`, 6 beats -> `{s1,s0}` = 1,3,1,3,1,3. Channels 0 and 2 are never selected.
- Backpressure: toggle `in_valid` 1,0,1,0 with `ch_en=4'b1111` -> `out_valid` pulses only after valid cycles, `i=0` on idle cycles, and `s1`/`s0` hold.
- Mid-stream disable: while on channel 2 with `dwell_cnt=0`, clear `ch_en[2]` -> `in_ready` low for 1 cycle (SKIP), then beats resume on channel 3. Clearing `ch_en` entirely -> IDLE, `in_ready=0`.
- Counter wrap with `CNT_W=3`: 9 accepted beats -> `beat_total` reads 1.
- Assert `rst_n=0` asynchronously mid-beat -> all outputs return to reset values before the next `clk` edge. After release, the first beat goes to channel 0.
